// File: rtl/candy_ctrl_seq_if.sv
// Handshake bundle between the candy core units and the multicycle control sequencer.
//   master : core side, drives run / stage_done / skip_mask / flush and observes status
//   slave  : sequencer side, drives stage_en / stage_start / pc_enable / busy /
//            cur_stage / retire_count / timeout_err
interface candy_ctrl_seq_if #(
    parameter int unsigned STAGES  = 4,
    parameter int unsigned STAGE_W = 2,
    parameter int unsigned CNT_W   = 16
);
    logic               run;
    logic [STAGES-1:0]  stage_done;
    logic [STAGES-1:0]  skip_mask;
    logic               flush;
    logic [STAGES-1:0]  stage_en;
    logic [STAGES-1:0]  stage_start;
    logic               pc_enable;
    logic               busy;
    logic [STAGE_W-1:0] cur_stage;
    logic [CNT_W-1:0]   retire_count;
    logic               timeout_err;

    modport master (
        output run, stage_done, skip_mask, flush,
        input  stage_en, stage_start, pc_enable, busy, cur_stage, retire_count, timeout_err
    );

    modport slave (
        input  run, stage_done, skip_mask, flush,
        output stage_en, stage_start, pc_enable, busy, cur_stage, retire_count, timeout_err
    );
endinterface

// File: rtl/candy_ctrl_seq.sv
// Parametrised multicycle control sequencer for the candy core.
// Steps an instruction through STAGES stages (0 = fetch, STAGES-1 = retire), holding each
// stage until its unit reports done, skipping masked stages and honouring flush.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - candy_ctrl_seq_if.slave: run/stage_done/skip_mask/flush in; stage_en,
//          stage_start, pc_enable, busy, cur_stage, retire_count, timeout_err out
// Optional feature: define CANDY_SEQ_TIMEOUT_EN to enable the per-stage watchdog
// (TIMEOUT_CYCLES); without it timeout_err is constant 0.
module candy_ctrl_seq #(
    parameter int unsigned STAGES         = 4,
    parameter int unsigned STAGE_W        = 2,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    candy_ctrl_seq_if.slave  bus
);

    if (STAGES < 2 || STAGE_W < $clog2(STAGES) || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("candy_ctrl_seq: illegal parameter combination");
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [STAGES-1:0]  en_q, en_d;
    logic [STAGES-1:0]  start_q, start_d;
    logic               pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               enter;      // entering a stage this cycle (drives start pulse)
    logic               timeout_hit;
    logic [STAGE_W-1:0] nxt_stage;
    logic               nxt_found;
    logic               locked;     // sticky error blocks new issue
    logic               expired;

`ifdef CANDY_SEQ_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            err_q, err_d;

    // tmr_q is 0 on the entry cycle, so TIMEOUT_CYCLES-1 marks the last allowed cycle
    assign expired = (state_q == StRun) && (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
    assign locked  = err_q;
`else
    assign expired = 1'b0;
    assign locked  = 1'b0;
`endif

    // Lowest non-skipped stage above the current one; descending scan so lowest wins.
    always_comb begin
        nxt_stage = '0;
        nxt_found = 1'b0;
        for (int j = int'(STAGES) - 1; j >= 0; j--) begin
            if (j > int'(stage_q) && !bus.skip_mask[j]) begin
                nxt_stage = STAGE_W'(j);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        pc_d        = 1'b0;
        enter       = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.run && !locked) begin
                    state_d = StRun;
                    stage_d = '0;
                    enter   = 1'b1;
                end
            end
            StRun: begin
                if (bus.flush) begin
                    // flush wins over a simultaneous done, even on the retiring stage
                    stage_d = '0;
                    if (bus.run) begin
                        enter = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus.stage_done[stage_q]) begin
                    if (nxt_found) begin
                        stage_d = nxt_stage;
                        enter   = 1'b1;
                    end else begin
                        pc_d    = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        stage_d = '0;
                        if (bus.run) begin
                            enter = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else if (expired) begin
                    timeout_hit = 1'b1;
                    state_d     = StIdle;
                    stage_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                stage_d = '0;
            end
        endcase

        en_d = '0;
        if (state_d == StRun) begin
            en_d[stage_d] = 1'b1;
        end
        start_d = enter ? en_d : '0;
    end

`ifdef CANDY_SEQ_TIMEOUT_EN
    always_comb begin
        err_d = err_q | timeout_hit;
        tmr_d = '0;
        if (state_d == StRun && !enter) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            en_q    <= '0;
            start_q <= '0;
            pc_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            en_q    <= en_d;
            start_q <= start_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stage_en     = en_q;
    assign bus.stage_start  = start_q;
    assign bus.pc_enable    = pc_q;
    assign bus.busy         = (state_q == StRun);
    assign bus.cur_stage    = stage_q;
    assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_candy_ctrl_seq.sv
module tb_candy_ctrl_seq;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    candy_ctrl_seq_if #(.STAGES(4), .STAGE_W(2), .CNT_W(16)) bus ();

    candy_ctrl_seq #(
        .STAGES(4), .STAGE_W(2), .CNT_W(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        flush;
        logic [3:0]  done;
        logic [3:0]  skip;
        logic [3:0]  en;
        logic [3:0]  st;
        logic        pc;
        logic        busy;
        logic [1:0]  cs;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rn, logic fl, logic [3:0] d, logic [3:0] sk,
                                logic [3:0] en, logic [3:0] st, logic pc, logic b,
                                logic [1:0] cs, logic [15:0] cnt);
        vec_t v;
        v = '{rst: r, run: rn, flush: fl, done: d, skip: sk, en: en, st: st, pc: pc,
              busy: b, cs: cs, cnt: cnt};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] outs();
        return {bus.stage_en, bus.stage_start, bus.pc_enable, bus.busy, bus.cur_stage,
                bus.retire_count};
    endfunction

    int cnt_en;
    int cnt_st;

    initial begin
        bus.run = 1'b0;
        bus.stage_done = '0;
        bus.skip_mask = '0;
        bus.flush = 1'b0;

        // rst run fl done skip | en st pc busy cs cnt
        vecs.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // all stages zero-wait
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 0, 1, 3, 0));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 0, 1, 2, 1));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 0, 1, 3, 1));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 0, 1, 1, 2));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 0, 1, 2, 2));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 0, 1, 3, 2));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 3));
        // stage 2 skipped
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0100, 4'b0010, 4'b0010, 0, 1, 1, 3));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0100, 4'b1000, 4'b1000, 0, 1, 3, 3));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0100, 4'b0001, 4'b0001, 1, 1, 0, 4));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0100, 4'b0010, 4'b0010, 0, 1, 1, 4));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0100, 4'b1000, 4'b1000, 0, 1, 3, 4));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0100, 4'b0001, 4'b0001, 1, 1, 0, 5));
        // hold in stage 0, then drop run during stage 1
        vecs.push_back(mk(0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 5));
        vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 0, 1, 1, 5));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, 1, 1, 5));
        vecs.push_back(mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 0, 1, 2, 5));
        vecs.push_back(mk(0, 0, 0, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 0, 1, 3, 5));
        vecs.push_back(mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 6));
        // flush in idle is ignored
        vecs.push_back(mk(0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 6));
        vecs.push_back(mk(0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0, 6));

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            bus.run        = vecs[i].run;
            bus.flush      = vecs[i].flush;
            bus.stage_done = vecs[i].done;
            bus.skip_mask  = vecs[i].skip;
            step();
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].en, vecs[i].st, vecs[i].pc, vecs[i].busy, vecs[i].cs,
                     vecs[i].cnt}));
            chk($sformatf("vec%0d_terr", i), 64'(bus.timeout_err), 64'd0);
        end

        // stage 1 completes 5 cycles after entry
        bus.run = 1'b1;
        bus.stage_done = 4'b0001;
        step();
        cnt_en = 0;
        cnt_st = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.stage_en[1]) cnt_en++;
            if (bus.stage_start[1]) cnt_st++;
            bus.stage_done = (i == 5) ? 4'b0010 : 4'b0000;
            step();
        end
        chk("wait_en_cycles", 64'(cnt_en), 64'd6);
        chk("wait_start_pulses", 64'(cnt_st), 64'd1);
        chk("wait_next_stage", 64'(bus.stage_en), 64'b0100);

        // flush with done on the last stage
        bus.stage_done = 4'b0100;
        step();
        chk("to_stage3", 64'(bus.stage_en), 64'b1000);
        bus.flush = 1'b1;
        bus.stage_done = 4'b1000;
        step();
        chk("flush_run", 64'({bus.stage_en, bus.stage_start, bus.pc_enable, bus.retire_count}),
            64'({4'b0001, 4'b0001, 1'b0, 16'd6}));
        bus.run = 1'b0;
        bus.stage_done = 4'b0001;
        step();
        chk("flush_idle", 64'({bus.busy, bus.stage_en, bus.pc_enable, bus.retire_count}),
            64'({1'b0, 4'b0000, 1'b0, 16'd6}));
        bus.flush = 1'b0;

        // reset mid-instruction
        bus.run = 1'b1;
        bus.stage_done = 4'b0000;
        step();
        bus.stage_done = 4'b1111;
        step();
        rst = 1'b1;
        step();
        chk("mid_reset", 64'({outs(), bus.timeout_err}), 64'd0);
        rst = 1'b0;

        // watchdog
        bus.stage_done = 4'b0000;
        step();
        bus.stage_done = 4'b0001;
        step();
        bus.stage_done = 4'b0000;
`ifdef CANDY_SEQ_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("wd_last_cycle", 64'({bus.busy, bus.timeout_err, bus.stage_en}),
            64'({1'b1, 1'b0, 4'b0010}));
        step();
        chk("wd_trip", 64'({bus.busy, bus.timeout_err, bus.stage_en}),
            64'({1'b0, 1'b1, 4'b0000}));
        repeat (3) step();
        chk("wd_run_ignored", 64'({bus.busy, bus.timeout_err}), 64'({1'b0, 1'b1}));
        rst = 1'b1;
        step();
        chk("wd_rst_clear", 64'({bus.busy, bus.timeout_err}), 64'd0);
        rst = 1'b0;
        step();
        chk("wd_rerun", 64'(bus.stage_en), 64'b0001);
`else
        repeat (20) step();
        chk("no_wd_wait", 64'({bus.busy, bus.timeout_err, bus.stage_en}),
            64'({1'b1, 1'b0, 4'b0010}));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
